nes_controller_reader: RTL

Polls a standard NES gamepad over its latch/pulse/data serial protocol and deposits the decoded 8-button state into data memory through BRAM port B. It is the stage directly upstream of the CPU's controller input path: it produces the address, data word and write enable that land on `addr_b`, `data_b` and `we_b`. This replaces static GIO pin sampling with a timed serial scan, so programs such as Pong read the controller from a fixed memory word.

---
 rtl/nes_controller_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nes_controller_reader.sv
// NES gamepad poller: periodic latch/pulse scan of the serial pad, result written to BRAM port B.
// Optional macro NES_DEBOUNCE_EN: publish a scan only when it matches the previous scan.
module nes_controller_reader #(
    parameter int          CLK_DIV     = 300,
    parameter int          POLL_PERIOD = 833333,
    parameter logic [15:0] NES_ADDR    = 16'h00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nes_data,
    output logic        nes_latch,
    output logic        nes_pulse,
    output logic [7:0]  buttons,
    output logic [15:0] nes_addr,
    output logic [15:0] nes_word,
    output logic        we_b
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_PULSE_HI,
        S_PULSE_LO,
        S_WRITE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [6:0]      r_shift;
    logic [7:0]      r_buttons;
    logic [TW-1:0]   r_timer;
    logic            r_pending;
    logic            w_wrap;
    logic            w_last;
    logic            w_bit;
    logic            w_sample;
    logic            w_done;
    logic [7:0]      w_scan;

    assign w_bit    = ~r_sync[1];
    assign w_wrap   = (r_timer == TIMER_LAST);
    assign w_last   = (r_cnt == ((r_state == S_LATCH) ? LATCH_LAST : H_LAST));
    assign w_scan   = {w_bit, r_shift};
    assign buttons  = r_buttons;
    assign nes_addr = NES_ADDR;
    assign nes_word = {8'h00, r_buttons};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], nes_data};
            r_timer <= w_wrap ? '0 : r_timer + 1'b1;
            // A wrap wins over the clear so a request arriving as a scan starts is not lost.
            if (w_wrap)
                r_pending <= 1'b1;
            else if (r_state == S_IDLE && r_pending)
                r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE || w_next != r_state)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_GAP && w_last)
                r_idx <= 3'd1;
            else if (r_state == S_PULSE_LO && w_last)
                r_idx <= r_idx + 1'b1;
            if (w_sample && !w_done)
                r_shift <= {w_bit, r_shift[6:1]};
        end
    end

    always_comb begin
        w_next    = r_state;
        nes_latch = 1'b0;
        nes_pulse = 1'b0;
        we_b      = 1'b0;
        w_sample  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending)
                    w_next = S_LATCH;
            end
            S_LATCH: begin
                nes_latch = 1'b1;
                if (w_last)
                    w_next = S_GAP;
            end
            S_GAP: begin
                if (w_last) begin
                    w_sample = 1'b1;
                    w_next   = S_PULSE_HI;
                end
            end
            S_PULSE_HI: begin
                nes_pulse = 1'b1;
                if (w_last)
                    w_next = S_PULSE_LO;
            end
            S_PULSE_LO: begin
                if (w_last) begin
                    w_sample = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_done = 1'b1;
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_PULSE_HI;
                    end
                end
            end
            S_WRITE: begin
                we_b   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Buttons load on the edge entering WRITE so they change together with we_b rising.
`ifdef NES_DEBOUNCE_EN
    logic [7:0] r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= '0;
            r_buttons <= '0;
        end else if (w_done) begin
            r_prev <= w_scan;
            if (w_scan == r_prev)
                r_buttons <= w_scan;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_buttons <= '0;
        else if (w_done)
            r_buttons <= w_scan;
    end
`endif

endmodule
